// File: rtl/dvbc_rs_sequencer_pkg.sv
// Shared constants and FSM encoding for the DVB-C RS(204,188) encoder sequencer.
package dvbc_rs_sequencer_pkg;

  localparam int          DVBC_PKT_LEN   = 188;
  localparam int          DVBC_PAR_LEN   = 16;
  localparam logic [7:0]  DVBC_SYNC_BYTE = 8'h47;
  localparam logic [7:0]  DVBC_SYNC_INV  = 8'hB8;
  localparam int          DVBC_GRP_LEN   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/dvbc_rs_sequencer.sv
// Frames 188-byte TS packets into the RS encoder, inserts 16 parity beats and
// tracks the 8-packet sync-inversion group.
module dvbc_rs_sequencer
  import dvbc_rs_sequencer_pkg::*;
#(
  parameter bit         SIMULATION = 1'b0,
  parameter bit         DEBUG      = 1'b0,
  parameter int         PKT_LEN    = DVBC_PKT_LEN,
  parameter int         PAR_LEN    = DVBC_PAR_LEN,
  parameter logic [7:0] SYNC_BYTE  = DVBC_SYNC_BYTE,
  parameter int         GRP_LEN    = DVBC_GRP_LEN
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  input  logic        s_sop_i,
  output logic        s_ready_o,
  output logic [7:0]  rs_data_o,
  output logic        rs_valid_o,
  input  logic        rs_ready_i,
  output logic        rs_first_o,
  output logic        rs_last_o,
  output logic        rs_par_o,
  output logic        rs_abort_o,
  output logic        sync_inv_o,
  output logic        busy_o,
  output logic [31:0] pkt_cnt_o,
  output logic [15:0] err_cnt_o,
  output logic [1:0]  dbg_state_o
);

  localparam int IW = $clog2(PKT_LEN);
  localparam int PW = $clog2(PAR_LEN);
  localparam int GW = $clog2(GRP_LEN);

  state_e        state;
  logic [IW-1:0] idx;
  logic [PW-1:0] pidx;
  logic [GW-1:0] grp;
  logic          abort_q;
  logic [31:0]   pkt_cnt;
  logic [15:0]   err_cnt;

  logic sop_ok, sop_bad, idx_last, pidx_last;

  // en_i only gates packet starts; an open packet always runs to the end of parity.
  assign sop_ok    = s_valid_i & s_sop_i & (s_data_i == SYNC_BYTE) & en_i;
  assign sop_bad   = s_valid_i & s_sop_i & (s_data_i != SYNC_BYTE) & en_i;
  assign idx_last  = (idx == IW'(PKT_LEN - 1));
  assign pidx_last = (pidx == PW'(PAR_LEN - 1));

  assign rs_data_o   = s_data_i;
  assign rs_abort_o  = abort_q;
  assign busy_o      = (state != ST_IDLE);
  assign pkt_cnt_o   = pkt_cnt;
  assign err_cnt_o   = err_cnt;
  assign dbg_state_o = DEBUG ? 2'(state) : 2'b00;
  assign sync_inv_o  = rs_first_o & (grp == '0);

  always_comb begin
    s_ready_o  = 1'b0;
    rs_valid_o = 1'b0;
    rs_first_o = 1'b0;
    rs_last_o  = 1'b0;
    rs_par_o   = 1'b0;
    case (state)
      ST_IDLE: if (en_i) begin
        s_ready_o  = sop_ok ? rs_ready_i : 1'b1;
        rs_valid_o = sop_ok;
        rs_first_o = sop_ok;
      end
      // A premature sop is held off so IDLE can re-evaluate it next cycle.
      ST_DATA: if (!(s_valid_i & s_sop_i)) begin
        s_ready_o  = rs_ready_i;
        rs_valid_o = s_valid_i;
        rs_last_o  = idx_last;
      end
      ST_PARITY: begin
        rs_valid_o = 1'b1;
        rs_par_o   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= ST_IDLE;
      idx     <= '0;
      pidx    <= '0;
      grp     <= '0;
      abort_q <= 1'b0;
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      abort_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sop_ok & rs_ready_i) begin
            idx   <= IW'(1);
            state <= ST_DATA;
          end
          if (sop_bad && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
        ST_DATA: begin
          if (s_valid_i & s_sop_i) begin
            abort_q <= 1'b1;
            state   <= ST_IDLE;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          end else if (s_valid_i & rs_ready_i) begin
            idx <= idx + IW'(1);
            if (idx_last) begin
              pidx  <= '0;
              state <= ST_PARITY;
            end
          end
        end
        ST_PARITY: if (rs_ready_i) begin
          pidx <= pidx + PW'(1);
          if (pidx_last) begin
            pkt_cnt <= pkt_cnt + 32'd1;
            grp     <= (grp == GW'(GRP_LEN - 1)) ? '0 : grp + GW'(1);
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  generate
    if (SIMULATION) begin : g_sim
      logic rdy_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdy_q <= 1'b0;
        else begin
          rdy_q <= rs_ready_i;
          if (state == ST_PARITY && !rs_valid_o && rs_ready_i != rdy_q)
            $error("rs_ready_i toggled with rs_valid_o low in PARITY");
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_dvbc_rs_sequencer.sv
// Directed bench for dvbc_rs_sequencer: framing, parity insertion, abort, grouping.
module tb_dvbc_rs_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b1;
  logic [7:0]  s_data_i = 8'h00;
  logic        s_valid_i = 1'b0;
  logic        s_sop_i = 1'b0;
  logic        rs_ready_i = 1'b1;
  logic        s_ready_o, rs_valid_o, rs_first_o, rs_last_o, rs_par_o;
  logic        rs_abort_o, sync_inv_o, busy_o;
  logic [7:0]  rs_data_o;
  logic [31:0] pkt_cnt_o;
  logic [15:0] err_cnt_o;
  logic [1:0]  dbg_state_o;

  int n_chk = 0, n_fail = 0;
  bit rand_en = 1'b0;

  dvbc_rs_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_sop_i(s_sop_i), .s_ready_o(s_ready_o),
    .rs_data_o(rs_data_o), .rs_valid_o(rs_valid_o), .rs_ready_i(rs_ready_i),
    .rs_first_o(rs_first_o), .rs_last_o(rs_last_o), .rs_par_o(rs_par_o),
    .rs_abort_o(rs_abort_o), .sync_inv_o(sync_inv_o), .busy_o(busy_o),
    .pkt_cnt_o(pkt_cnt_o), .err_cnt_o(err_cnt_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #1;
    rs_ready_i = rand_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  // Beat log captured mid-cycle, where a high valid & ready means the next edge transfers.
  logic [7:0] q_data[$];
  bit         q_first[$], q_last[$], q_par[$], q_inv[$];
  int         q_cyc[$];
  int         cyc = 0, n_abort = 0, n_rdylo = 0;

  always @(negedge clk_i) begin
    cyc++;
    if (rs_abort_o) n_abort++;
    if (!s_ready_o) n_rdylo++;
    if (rst_ni && rs_valid_o && rs_ready_i) begin
      q_data.push_back(rs_data_o);
      q_first.push_back(rs_first_o);
      q_last.push_back(rs_last_o);
      q_par.push_back(rs_par_o);
      q_inv.push_back(sync_inv_o);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Expected layout of one 204-beat packet: byte0 = 0x47, byte i = seed+i, then 16 parity beats.
  function automatic int pkt_errs(input int o, input int seed);
    int e = 0;
    logic [7:0] exp_d;
    if (q_data.size() < o + 204) return 999;
    for (int i = 0; i < 204; i++) begin
      if (q_first[o+i] != (i == 0))  e++;
      if (q_last[o+i]  != (i == 187)) e++;
      if (q_par[o+i]   != (i >= 188)) e++;
      if (i < 188) begin
        exp_d = (i == 0) ? 8'h47 : 8'(seed + i);
        if (q_data[o+i] !== exp_d) e++;
      end
    end
    return e;
  endfunction

  task automatic do_reset();
    s_valid_i = 1'b0;
    s_sop_i   = 1'b0;
    rst_ni    = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic idle(input int n);
    s_valid_i = 1'b0;
    s_sop_i   = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Sends bytes start..start+n-1 of a packet; valid stays high afterwards for back-to-back use.
  task automatic send_pkt(input logic [7:0] b0, input int seed, input int start,
                          input int n, input bit sop);
    bit ok;
    int t;
    for (int i = start; i < start + n; i++) begin
      s_valid_i = 1'b1;
      s_sop_i   = sop && (i == 0);
      s_data_i  = (i == 0) ? b0 : 8'(seed + i);
      t = 0;
      do begin
        @(negedge clk_i);
        ok = s_ready_o;
        @(posedge clk_i);
        #1;
        t++;
      end while (!ok && t < 2000);
      if (!ok) begin
        n_chk++; n_fail++;
        $display("FAIL send_timeout: byte %0d not accepted, got stall, expected accept", i);
        s_valid_i = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    en_i   = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_chk++; if (s_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 1", s_ready_o); end
    n_chk++; if ({rs_valid_o, rs_first_o, rs_last_o, rs_par_o, rs_abort_o, sync_inv_o, busy_o} !== 7'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0", {rs_valid_o, rs_first_o, rs_last_o, rs_par_o, rs_abort_o, sync_inv_o, busy_o}); end
    n_chk++; if (pkt_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt_o); end
    n_chk++; if (err_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt_o); end
    n_chk++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL reset_dbg: got %0d expected 0", dbg_state_o); end
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_clean_packet();
    int b, r0, e;
    do_reset();
    b = q_data.size(); r0 = n_rdylo;
    send_pkt(8'h47, 3, 0, 188, 1'b1);
    idle(30);
    n_chk++; if (q_data.size() - b != 204) begin n_fail++; $display("FAIL clean_beats: got %0d expected 204", q_data.size() - b); end
    e = pkt_errs(b, 3);
    n_chk++; if (e !== 0) begin n_fail++; $display("FAIL clean_layout: got %0d bad fields expected 0", e); end
    n_chk++; if (n_rdylo - r0 != 16) begin n_fail++; $display("FAIL clean_stall: got %0d cycles expected 16", n_rdylo - r0); end
    n_chk++; if (pkt_cnt_o !== 32'd1) begin n_fail++; $display("FAIL clean_pkt_cnt: got %0d expected 1", pkt_cnt_o); end
    n_chk++; if (q_data.size() > b && q_inv[b] !== 1'b1) begin n_fail++; $display("FAIL clean_sync_inv: got %b expected 1", q_inv[b]); end
  endtask

  task automatic test_back_to_back();
    int b, e, ei, gap;
    do_reset();
    b = q_data.size();
    for (int k = 0; k < 9; k++) send_pkt(8'h47, k * 13, 0, 188, 1'b1);
    idle(30);
    n_chk++; if (q_data.size() - b != 9 * 204) begin n_fail++; $display("FAIL b2b_beats: got %0d expected 1836", q_data.size() - b); end
    e = 0; ei = 0;
    for (int k = 0; k < 9; k++) begin
      e += pkt_errs(b + k * 204, k * 13);
      if (q_data.size() > b + k * 204 && q_inv[b + k * 204] != (k % 8 == 0)) ei++;
    end
    n_chk++; if (e !== 0) begin n_fail++; $display("FAIL b2b_layout: got %0d bad fields expected 0", e); end
    n_chk++; if (ei !== 0) begin n_fail++; $display("FAIL b2b_sync_inv: got %0d wrong packets expected 0", ei); end
    gap = (q_data.size() >= b + 1836) ? q_cyc[b + 1835] - q_cyc[b] : -1;
    n_chk++; if (gap != 1835) begin n_fail++; $display("FAIL b2b_span: got %0d cycles expected 1835", gap); end
    n_chk++; if (pkt_cnt_o !== 32'd9) begin n_fail++; $display("FAIL b2b_pkt_cnt: got %0d expected 9", pkt_cnt_o); end
  endtask

  task automatic test_abort();
    int b, a0, e;
    do_reset();
    b = q_data.size(); a0 = n_abort;
    send_pkt(8'h47, 10, 0, 100, 1'b1);
    send_pkt(8'h47, 50, 0, 188, 1'b1);
    idle(30);
    n_chk++; if (q_data.size() - b != 304) begin n_fail++; $display("FAIL abort_beats: got %0d expected 304", q_data.size() - b); end
    e = 0;
    if (q_data.size() >= b + 100)
      for (int i = 0; i < 100; i++) begin
        if (q_data[b+i] !== ((i == 0) ? 8'h47 : 8'(10 + i))) e++;
        if (q_first[b+i] != (i == 0) || q_last[b+i] || q_par[b+i]) e++;
      end
    e += pkt_errs(b + 100, 50);
    n_chk++; if (e !== 0) begin n_fail++; $display("FAIL abort_layout: got %0d bad fields expected 0", e); end
    n_chk++; if (n_abort - a0 != 1) begin n_fail++; $display("FAIL abort_pulse: got %0d pulses expected 1", n_abort - a0); end
    n_chk++; if (err_cnt_o !== 16'd1) begin n_fail++; $display("FAIL abort_err_cnt: got %0d expected 1", err_cnt_o); end
    n_chk++; if (pkt_cnt_o !== 32'd1) begin n_fail++; $display("FAIL abort_pkt_cnt: got %0d expected 1", pkt_cnt_o); end
  endtask

  task automatic test_bad_sync();
    int b, e;
    do_reset();
    b = q_data.size();
    send_pkt(8'h48, 0, 0, 1, 1'b1);
    send_pkt(8'h47, 77, 0, 188, 1'b1);
    idle(30);
    n_chk++; if (q_data.size() - b != 204) begin n_fail++; $display("FAIL badsync_beats: got %0d expected 204", q_data.size() - b); end
    e = pkt_errs(b, 77);
    n_chk++; if (e !== 0) begin n_fail++; $display("FAIL badsync_layout: got %0d bad fields expected 0", e); end
    n_chk++; if (err_cnt_o !== 16'd1) begin n_fail++; $display("FAIL badsync_err_cnt: got %0d expected 1", err_cnt_o); end
    n_chk++; if (pkt_cnt_o !== 32'd1) begin n_fail++; $display("FAIL badsync_pkt_cnt: got %0d expected 1", pkt_cnt_o); end
  endtask

  task automatic test_random_ready();
    int b, e;
    do_reset();
    rand_en = 1'b1;
    b = q_data.size();
    for (int k = 0; k < 20; k++) send_pkt(8'h47, k * 5 + 1, 0, 188, 1'b1);
    idle(80);
    rand_en = 1'b0;
    idle(5);
    n_chk++; if (q_data.size() - b != 20 * 204) begin n_fail++; $display("FAIL rand_beats: got %0d expected 4080", q_data.size() - b); end
    e = 0;
    for (int k = 0; k < 20; k++) e += pkt_errs(b + k * 204, k * 5 + 1);
    n_chk++; if (e !== 0) begin n_fail++; $display("FAIL rand_layout: got %0d bad fields expected 0", e); end
    n_chk++; if (pkt_cnt_o !== 32'd20) begin n_fail++; $display("FAIL rand_pkt_cnt: got %0d expected 20", pkt_cnt_o); end
  endtask

  task automatic test_enable_drop_and_reset();
    int b, e, sz;
    do_reset();
    en_i = 1'b1;
    b = q_data.size();
    send_pkt(8'h47, 9, 0, 50, 1'b1);
    en_i = 1'b0;
    send_pkt(8'h00, 9, 50, 138, 1'b0);
    idle(30);
    n_chk++; if (q_data.size() - b != 204) begin n_fail++; $display("FAIL endrop_beats: got %0d expected 204", q_data.size() - b); end
    e = pkt_errs(b, 9);
    n_chk++; if (e !== 0) begin n_fail++; $display("FAIL endrop_layout: got %0d bad fields expected 0", e); end
    n_chk++; if (pkt_cnt_o !== 32'd1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL endrop_done: got pkt %0d busy %b expected 1 0", pkt_cnt_o, busy_o); end
    sz = q_data.size();
    s_valid_i = 1'b1; s_sop_i = 1'b1; s_data_i = 8'h47;
    repeat (5) @(posedge clk_i);
    #1;
    n_chk++; if (s_ready_o !== 1'b0 || q_data.size() != sz) begin
      n_fail++; $display("FAIL endrop_idle: got ready %b beats %0d expected 0 0", s_ready_o, q_data.size() - sz); end
    s_valid_i = 1'b0; s_sop_i = 1'b0;
    en_i = 1'b1;
    send_pkt(8'h47, 2, 0, 50, 1'b1);
    rst_ni = 1'b0;
    #1;
    n_chk++; if (busy_o !== 1'b0 || pkt_cnt_o !== 32'd0 || err_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL midreset_state: got busy %b pkt %0d err %0d expected 0 0 0", busy_o, pkt_cnt_o, err_cnt_o); end
    n_chk++; if ({rs_valid_o, rs_last_o, rs_par_o, rs_abort_o, s_ready_o} !== 5'b00001) begin
      n_fail++; $display("FAIL midreset_outputs: got %b expected 00001", {rs_valid_o, rs_last_o, rs_par_o, rs_abort_o, s_ready_o}); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_clean_packet();
    test_back_to_back();
    test_abort();
    test_bad_sync();
    test_random_ready();
    test_enable_drop_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
